// File: rtl/aes_key_expand_if.sv
// Bus between the AES key expander and its surroundings: key request,
// external S-box lookup and the round-key valid/ready stream.
interface aes_key_expand_if;
  logic         en;
  logic         start;
  logic [1:0]   key_mode;
  logic [255:0] key_i;
  logic [31:0]  sub_o;
  logic [31:0]  sub_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
  logic         err;

  // Expander side
  modport slave (
    input  en, start, key_mode, key_i, sub_i, rk_ready,
    output sub_o, rk_o, rk_idx, rk_valid, busy, done, err
  );

  // Requester / consumer side
  modport master (
    output en, start, key_mode, key_i, sub_i, rk_ready,
    input  sub_o, rk_o, rk_idx, rk_valid, busy, done, err
  );
endinterface

// File: rtl/aes_key_expand.sv
// AES key expansion (128/192/256) producing one schedule word per enabled
// cycle and streaming 128-bit round keys over a valid/ready handshake.
// The S-box is external: sub_o goes out, sub_i comes back in the same cycle.
// The only word storage is a MAX_NK-deep shift window. On start the key
// words are loaded into it in reverse order; while i < Nk the oldest word is
// recirculated, which both emits the key words and leaves the window holding
// w[0..Nk-1] in the right order for i = Nk.
module aes_key_expand #(
  parameter int MAX_NK = 8
) (
  input logic             clk,
  input logic             nrst,
  aes_key_expand_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of key words for a mode (illegal mode maps to 8 so it is
  // rejected whenever the core is built for fewer words).
  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    logic [3:0] nk;
    case (mode)
      2'd0:    nk = 4'd4;
      2'd1:    nk = 4'd6;
      2'd2:    nk = 4'd8;
      default: nk = 4'd8;
    endcase
    return nk;
  endfunction

  // Index of the final schedule word, 4*Nr+3.
  function automatic logic [5:0] last_of(input logic [1:0] mode);
    logic [5:0] last;
    case (mode)
      2'd0:    last = 6'd43;
      2'd1:    last = 6'd51;
      2'd2:    last = 6'd59;
      default: last = 6'd43;
    endcase
    return last;
  endfunction

  // Left rotate by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;

  logic [31:0]  r_win [MAX_NK];
  logic [31:0]  r_asm [3];
  logic [5:0]   r_i;
  logic [2:0]   r_ph;
  logic [7:0]   r_rcon;
  logic [1:0]   r_mode;
  logic [127:0] r_rk;
  logic [3:0]   r_rk_idx;
  logic         r_rk_valid;
  logic         r_err;

  logic [31:0]  w_key_word [8];
  logic [31:0]  w_load [MAX_NK];
  logic [3:0]   w_nk;
  logic [3:0]   w_nk_req;
  logic [5:0]   w_last;
  logic         w_req_legal;
  logic         w_start_ok;
  logic         w_start_bad;
  logic [31:0]  w_oldest;
  logic [31:0]  w_newest;
  logic         w_key_phase;
  logic         w_rot_step;
  logic         w_sub_step;
  logic [31:0]  w_sub_o;
  logic [31:0]  w_temp;
  logic [31:0]  w_word;
  logic         w_accept;
  logic         w_completes;
  logic         w_stall;
  logic         w_write;
  logic         w_ph_wrap;

  // Split the left-justified key into words and build the reversed window image
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_key_word[j] = bus.key_i[255 - 32*j -: 32];
    end
    w_nk_req = nk_of(bus.key_mode);
    for (int k = 0; k < MAX_NK; k++) begin
      if (k < int'(w_nk_req)) begin
        w_load[k] = w_key_word[3'(int'(w_nk_req) - 1 - k)];
      end else begin
        w_load[k] = 32'h0000_0000;
      end
    end
  end

  // Start qualification, schedule position decode and handshake decode
  always_comb begin
    w_nk        = nk_of(r_mode);
    w_last      = last_of(r_mode);
    w_req_legal = (bus.key_mode != 2'd3) && (int'(w_nk_req) <= MAX_NK);
    w_start_ok  = (r_state == ST_IDLE) && bus.en && bus.start && w_req_legal;
    w_start_bad = (r_state == ST_IDLE) && bus.en && bus.start && !w_req_legal;
    w_key_phase = (r_i >= {2'b00, w_nk});
    w_ph_wrap   = ({1'b0, r_ph} == (w_nk - 4'd1));
    w_rot_step  = w_key_phase && (r_ph == 3'd0);
    w_sub_step  = w_key_phase && (w_nk == 4'd8) && (r_ph == 3'd4);
    w_accept    = r_rk_valid && bus.rk_ready && bus.en;
    w_completes = (r_i[1:0] == 2'b11);
    // Only a buffer-completing word has to wait for the consumer
    w_stall     = w_completes && r_rk_valid && !bus.rk_ready;
    w_write     = (r_state == ST_GEN) && bus.en && !w_stall;
  end

  // Window taps: w[i-1] is the newest entry, w[i-Nk] sits at position Nk-1
  always_comb begin
    w_newest = r_win[0];
    w_oldest = 32'h0000_0000;
    for (int k = 0; k < MAX_NK; k++) begin
      if (k == int'(w_nk) - 1) begin
        w_oldest = r_win[k];
      end else begin
        w_oldest = w_oldest;
      end
    end
  end

  // S-box request and next schedule word
  always_comb begin
    w_sub_o = 32'h0000_0000;
    w_temp  = w_newest;
    if (r_state == ST_GEN) begin
      if (w_rot_step) begin
        w_sub_o = rot_word(w_newest);
        w_temp  = bus.sub_i ^ {r_rcon, 24'h00_0000};
      end else if (w_sub_step) begin
        w_sub_o = w_newest;
        w_temp  = bus.sub_i;
      end else begin
        w_sub_o = w_newest;
        w_temp  = w_newest;
      end
    end else begin
      w_sub_o = 32'h0000_0000;
      w_temp  = w_newest;
    end
    if (w_key_phase) begin
      w_word = w_oldest ^ w_temp;
    end else begin
      w_word = w_oldest;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_GEN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (w_write && (r_i == w_last)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_GEN;
        end
      end
      ST_DRAIN: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Schedule datapath: window, counters, rcon, assembly buffer and round-key register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < MAX_NK; k++) begin
        r_win[k] <= 32'h0000_0000;
      end
      for (int k = 0; k < 3; k++) begin
        r_asm[k] <= 32'h0000_0000;
      end
      r_i        <= 6'd0;
      r_ph       <= 3'd0;
      r_rcon     <= 8'h01;
      r_mode     <= 2'd0;
      r_rk       <= 128'h0;
      r_rk_idx   <= 4'd0;
      r_rk_valid <= 1'b0;
      r_err      <= 1'b0;
    end else if (bus.en) begin
      r_err <= w_start_bad;
      if (w_start_ok) begin
        r_mode   <= bus.key_mode;
        r_i      <= 6'd0;
        r_ph     <= 3'd0;
        r_rcon   <= 8'h01;
        r_rk_idx <= 4'd0;
        for (int k = 0; k < MAX_NK; k++) begin
          r_win[k] <= w_load[k];
        end
      end else if (w_write) begin
        r_win[0] <= w_word;
        for (int k = 1; k < MAX_NK; k++) begin
          r_win[k] <= r_win[k-1];
        end
        r_i  <= r_i + 6'd1;
        r_ph <= w_ph_wrap ? 3'd0 : (r_ph + 3'd1);
        if (w_rot_step) begin
          r_rcon <= xtime(r_rcon);
        end
        if (w_completes) begin
          r_rk     <= {r_asm[0], r_asm[1], r_asm[2], w_word};
          r_rk_idx <= r_i[5:2];
        end else begin
          r_asm[r_i[1:0]] <= w_word;
        end
      end
      if (w_write && w_completes) begin
        r_rk_valid <= 1'b1;
      end else if (w_accept) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  assign bus.sub_o    = w_sub_o;
  assign bus.rk_o     = r_rk;
  assign bus.rk_idx   = r_rk_idx;
  assign bus.rk_valid = r_rk_valid;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.err      = r_err;
  // The final round key is the only one presented in DRAIN
  assign bus.done     = (r_state == ST_DRAIN) && w_accept;

endmodule
